x_ramb4_nibble_streamer: RTL and testbench
==========================================

Name: x_ramb4_nibble_streamer

Overview:
Read-side streamer for a 4096-bit dual-port block RAM whose port B is 4 bits wide (1024 x 4). On a START command it issues sequential port-B reads from START_ADDR, wrapping at the top of memory. It absorbs the RAM's 1-cycle registered read latency and presents the nibbles on a valid/ready stream. It sits directly downstream of the RAM's port B. Port A stays free for the 1-bit writer.

Parameters:
ADDR_W, 10, port-B address width (1024 nibbles)
DATA_W, 4, port-B data width
FIFO_DEPTH, 3, output buffer entries; must be >=3 for one nibble/cycle sustained

Ports:
CLK  input  1  single clock; RAM port B is clocked by the same CLK
RST  input  1  synchronous, active-high reset
START  input  1  command strobe; accepted only when BUSY=0
START_ADDR  input  ADDR_W  first nibble address
LEN  input  ADDR_W  nibble count; 0 encodes 2**ADDR_W (1024)
BUSY  output  1  command in progress
DONE  output  1  one-cycle pulse after final nibble is handed off
ADDRB  output  ADDR_W  to RAM port B address
ENB  output  1  to RAM port B enable (read strobe)
WEB  output  1  to RAM port B write enable; constant 0
RSTB  output  1  to RAM port B output reset; constant 0
DOB  input  DATA_W  from RAM port B data (registered, valid the cycle after ENB)
DOUT  output  DATA_W  stream data
DVALID  output  1  stream valid
DREADY  input  1  stream ready
DLAST  output  1  marks final nibble of the command; qualified by DVALID

Behaviour:
- Reset: RST high at a CLK edge clears the FSM to IDLE, FIFO to empty and the in-flight flag. It discards any outstanding read. It takes priority over all other inputs, including mid-command.
- Reset output values: BUSY=0, DONE=0, ENB=0, ADDRB=0, DVALID=0, DLAST=0, DOUT=0. WEB and RSTB are always 0.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: START=1 latches START_ADDR into the address counter and LEN into the issue and pop counters. Next state is FETCH. BUSY=1 from the next cycle.
  - FETCH: go to DRAIN when the last read has been issued.
  - DRAIN: go to IDLE after the DLAST handshake. DONE=1 for exactly the first IDLE cycle.
- START while BUSY=1 is ignored, with no effect on the running command. START in the DONE cycle is accepted.
- Read issue: ENB=1 in a cycle only if the state is FETCH, reads remain, and (FIFO occupancy + in-flight) < FIFO_DEPTH. Occupancy and in-flight are registered values, so there is no combinational path from DREADY to ENB.
- Address handling: ADDRB advances by 1 per issued read and wraps 1023 -> 0.
- Capture: a read issued in cycle k is written to the FIFO at the end of cycle k+1, from DOB.
- Stream outputs: DVALID = FIFO non-empty and DOUT = FIFO head. The head stays stable while DVALID=1 and DREADY=0. A pop occurs when DVALID and DREADY are both 1.
- DLAST=1 while the head entry is the final nibble. Track this with the pop counter reaching 1.
- Latency: START sampled at edge e0 -> ENB=1 with ADDRB=START_ADDR in the cycle after e0 -> DVALID=1 three cycles after e0.
- Throughput: with DREADY held at 1, one nibble per cycle is sustained.
- Simultaneous push and pop in one cycle: occupancy is unchanged.
- Full FIFO: no further issue until a pop. Data is never dropped or overwritten.
- Reset mid-command: the stream stops immediately with DVALID=0 and no DONE pulse.

Decomposition:
- Shared package: FSM state encoding (IDLE/FETCH/DRAIN), ADDR_W/DATA_W defaults, and the LEN-zero-means-full-depth constant.
- One sub-module: nibble_skid_fifo. It is a synchronous DATA_W x FIFO_DEPTH FIFO with push, pop, count, empty and full, and a synchronous active-high reset.

Test Plan:
- RAM preloaded so that nibble n = n[3:0]; START_ADDR=0, LEN=16, DREADY=1 -> DOUT 0..F on 16 consecutive cycles, first DVALID 3 cycles after START. DLAST on F, then DONE pulse 1 cycle later.
- START_ADDR=1022, LEN=4 -> ADDRB sequence 1022, 1023, 0, 1; DOUT E, F, 0, 1.
- LEN=0 from address 5 -> 1024 nibbles streamed. Address wraps once, the last nibble is read from address 4, and DLAST is on count 1024.
- DREADY toggled 1,0,0,1 repeatedly during LEN=8 -> ENB never issued with occupancy+in-flight=3. DOUT is stable while stalled, and all 8 nibbles arrive in order.
- START pulsed again mid-command with START_ADDR=100 -> ignored, and the original sequence completes unchanged. START in the DONE cycle -> accepted, with ENB the next cycle.
- RST asserted while 2 nibbles are buffered -> next cycle DVALID=0, BUSY=0, ENB=0, and no DONE pulse. A subsequent START works normally.

Source files
------------

// File: rtl/x_ramb4_nibble_streamer_pkg.sv
// Shared types and defaults for the RAMB4 port-B nibble streamer.
// LEN=0 encodes a full sweep of the memory (2**ADDR_W nibbles).
package x_ramb4_nibble_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 4;
    localparam int FIFO_DEPTH_DEF = 3;
    localparam int LEN_FULL_DEPTH = 0;

    function automatic int len_to_count(input int len, input int addr_w);
        return (len == LEN_FULL_DEPTH) ? (1 << addr_w) : len;
    endfunction

endpackage

// File: rtl/x_ramb4_nibble_streamer_nibble_skid_fifo.sv
// Small synchronous FIFO that buffers RAM read data in front of the stream port.
// Pushes into a full FIFO and pops from an empty one are ignored.
module nibble_skid_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CW-1:0]     count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok;
    logic              pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/x_ramb4_nibble_streamer.sv
// Streams sequential nibbles from RAMB4 port B onto a valid/ready interface,
// hiding the RAM's one-cycle registered read latency behind a small FIFO.
module x_ramb4_nibble_streamer
    import x_ramb4_nibble_streamer_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W-1:0] LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] ADDRB,
    output logic              ENB,
    output logic              WEB,
    output logic              RSTB,
    input  logic [DATA_W-1:0] DOB,
    output logic [DATA_W-1:0] DOUT,
    output logic              DVALID,
    input  logic              DREADY,
    output logic              DLAST,
    output state_e            STATE_DBG
);

    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [CNT_W-1:0]  pop_q, pop_d;
    logic              inflight_q;
    logic              done_q, done_d;

    logic [DATA_W-1:0] fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  start_cnt;
    logic              credit_ok;
    logic              enb;
    logic              handoff;
    logic              last_handoff;

    assign start_cnt = CNT_W'(len_to_count(int'(LEN), ADDR_W));
    // Credit uses only registered occupancy/in-flight, keeping DREADY off the ENB path.
    assign credit_ok = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < (CW + 1)'(FIFO_DEPTH);
    assign handoff      = !fifo_empty && DREADY;
    assign last_handoff = handoff && (pop_q == CNT_W'(1));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (START) state_d = ST_FETCH;
            ST_FETCH: if (enb && issue_q == CNT_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: if (last_handoff) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY   = (state_q != ST_IDLE);
        enb    = (state_q == ST_FETCH) && (issue_q != '0) && credit_ok && !fifo_full;
        DVALID = !fifo_empty;
        DLAST  = !fifo_empty && (pop_q == CNT_W'(1));
        DOUT   = fifo_empty ? '0 : fifo_head;
    end

    always_comb begin
        addr_d  = addr_q;
        issue_d = issue_q;
        pop_d   = pop_q;
        done_d  = (state_q == ST_DRAIN) && last_handoff;
        if (state_q == ST_IDLE && START) begin
            addr_d  = START_ADDR;
            issue_d = start_cnt;
            pop_d   = start_cnt;
        end
        if (enb) begin
            addr_d  = addr_q + ADDR_W'(1);
            issue_d = issue_q - CNT_W'(1);
        end
        if (handoff) begin
            pop_d = pop_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q     <= '0;
            issue_q    <= '0;
            pop_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            pop_q      <= pop_d;
            inflight_q <= enb;
            done_q     <= done_d;
        end
    end

    nibble_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (inflight_q),
        .push_data_i (DOB),
        .pop_i       (handoff),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign ENB       = enb;
    assign ADDRB     = addr_q;
    assign DONE      = done_q;
    assign WEB       = 1'b0;
    assign RSTB      = 1'b0;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_x_ramb4_nibble_streamer.sv
// Bench for x_ramb4_nibble_streamer: behavioural RAMB4 port B, directed commands,
// scoreboard queues for read addresses and streamed nibbles, monitor on the falling edge.
module tb_x_ramb4_nibble_streamer;
    import x_ramb4_nibble_streamer_pkg::*;

    localparam int AW = 10;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] len = '0;
    logic          dready = 1'b1;
    logic          busy, done, enb, web, rstb, dvalid, dlast;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dob, dout;
    state_e        dbg_state;

    logic [DW-1:0] ram [1024];
    int checks = 0;
    int failures = 0;
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_exp_q[$];
    logic          done_pending = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dout = '0;
    int occ_m = 0;
    int infl_m = 0;

    x_ramb4_nibble_streamer dut (
        .CLK        (clk),
        .RST        (rst),
        .START      (start),
        .START_ADDR (start_addr),
        .LEN        (len),
        .BUSY       (busy),
        .DONE       (done),
        .ADDRB      (addrb),
        .ENB        (enb),
        .WEB        (web),
        .RSTB       (rstb),
        .DOB        (dob),
        .DOUT       (dout),
        .DVALID     (dvalid),
        .DREADY     (dready),
        .DLAST      (dlast),
        .STATE_DBG  (dbg_state)
    );

    // Clock / reset / memory
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 4'(i);
    end

    always @(posedge clk) begin
        if (enb) dob <= ram[addrb];
    end

    // Independent occupancy model: reads in flight and nibbles buffered.
    always @(posedge clk) begin
        if (rst) begin
            occ_m  <= 0;
            infl_m <= 0;
        end else begin
            occ_m  <= occ_m + infl_m - ((dvalid && dready) ? 1 : 0);
            infl_m <= enb ? 1 : 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none t=%0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input int a, input int n_len);
        int n;
        logic [AW-1:0] ad;
        n = (n_len == 0) ? 1024 : n_len;
        for (int i = 0; i < n; i++) begin
            ad = AW'((a + i) % 1024);
            addr_exp_q.push_back(ad);
            exp_q.push_back({(i == n - 1), ad[3:0]});
        end
        start_addr = AW'(a);
        len        = AW'(n_len);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || addr_exp_q.size() != 0 || done_pending || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) fail_now("wait_idle_timeout");
        @(negedge clk);
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done_pending || done) begin
                    check("done_pulse", 32'(done), 32'(done_pending));
                    done_pending = 1'b0;
                end
                if (enb) begin
                    if (addr_exp_q.size() == 0) fail_now("unexpected_read");
                    else check("addrb", 32'(addrb), 32'(addr_exp_q.pop_front()));
                    check("issue_credit", 32'(occ_m + infl_m < 3), 32'(1));
                end
                if (prev_stall) check("dout_stable", 32'({dvalid, dout}), 32'({1'b1, prev_dout}));
                if (dvalid && dready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_nibble");
                    else check("stream_last_data", 32'({dlast, dout}), 32'(exp_q.pop_front()));
                    if (dlast) done_pending = 1'b1;
                end
                prev_stall = dvalid && !dready;
                prev_dout  = dout;
            end else begin
                prev_stall   = 1'b0;
                done_pending = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        int k;
        int vcount;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_enb", 32'(enb), 0);
        check("rst_addrb", 32'(addrb), 0);
        check("rst_dvalid", 32'(dvalid), 0);
        check("rst_dlast", 32'(dlast), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_web_rstb", 32'({web, rstb}), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        // 16 nibbles from 0 with latency and throughput checks
        issue_cmd(0, 16);
        @(negedge clk);
        check("lat_enb_c1", 32'({enb, addrb}), 32'({1'b1, 10'd0}));
        check("lat_dvalid_c1", 32'(dvalid), 0);
        check("lat_busy_c1", 32'(busy), 1);
        @(negedge clk);
        check("lat_dvalid_c2", 32'(dvalid), 0);
        @(negedge clk);
        check("lat_dvalid_c3", 32'(dvalid), 1);
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (dvalid) vcount++;
        end
        check("throughput_16", 32'(vcount), 15);
        wait_idle(40);

        // Wrap at the top of memory
        issue_cmd(1022, 4);
        wait_idle(40);

        // LEN=0 is a full 1024-nibble sweep from address 5
        issue_cmd(5, 0);
        wait_idle(1200);

        // Back-pressure pattern 1,0,0,1
        issue_cmd(40, 8);
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            dready = (k % 4 == 0) || (k % 4 == 3);
            tick();
            k++;
        end
        dready = 1'b1;
        wait_idle(50);

        // START during a command is ignored; START in the DONE cycle is accepted
        issue_cmd(10, 12);
        repeat (3) tick();
        check("busy_mid_cmd", 32'(busy), 1);
        start_addr = AW'(100);
        len        = AW'(5);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_now("done_wait_timeout");
        issue_cmd(300, 3);
        @(negedge clk);
        check("done_cycle_start_enb", 32'({enb, addrb}), 32'({1'b1, 10'd300}));
        wait_idle(40);

        // Reset with two nibbles buffered
        dready = 1'b0;
        issue_cmd(200, 8);
        repeat (3) tick();
        check("two_buffered_dvalid", 32'(dvalid), 1);
        rst = 1'b1;
        exp_q.delete();
        addr_exp_q.delete();
        tick();
        @(negedge clk);
        check("midrst_dvalid", 32'(dvalid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_enb", 32'(enb), 0);
        check("midrst_done", 32'(done), 0);
        rst = 1'b0;
        dready = 1'b1;
        tick();
        check("post_rst_done", 32'(done), 0);
        issue_cmd(500, 6);
        wait_idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
